poly_fold_reduce: RTL and testbench
===================================

# poly_fold_reduce

Parametrised output stage for the NTT polynomial multiplier. It reads the 2N-coefficient linear product from the result BRAMs, maps each word from the NTT prime P into a centred signed value, and folds the product modulo x^N−1, or x^N+1 when built with `POLY_FOLD_NEGACYCLIC_EN`. It then reduces the result modulo q = 2^q_log and streams coefficients out through an internal credit-managed FIFO with ready/valid handshaking. This block supersedes the fixed-width reduction/FIFO path of the current multiplier top: N, q, widths, memory latency and FIFO depth are all generic.

## Interface
- COEF_W, 24: BRAM word width; inputs are unsigned residues mod P.
- OUT_W, 13: output coefficient width.
- LOG_N_MAX, 11: width of n; maximum N = 2^LOG_N_MAX − 1.
- P, 12587009: NTT prime; P < 2^COEF_W.
- RD_LAT, 2: BRAM read latency in cycles, ≥1.
- FIFO_DEPTH, 8: output FIFO entries; power of two, ≥ RD_LAT+3.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-high reset (1 = reset).
- start  in  1  single-cycle request; sampled only in IDLE.
- n  in  LOG_N_MAX  ring dimension N, 2 ≤ N; captured on start.
- q_log  in  4  output modulus exponent, 1 ≤ q_log ≤ OUT_W; captured on start.
- negacyclic  in  1  fold sign select; captured on start.
- rd_en  out  1  read strobe, both ports.
- addr_lo  out  LOG_N_MAX+1  low-half address i.
- addr_hi  out  LOG_N_MAX+1  high-half address i+N.
- rdata_lo  in  COEF_W  data for addr_lo, RD_LAT after rd_en.
- rdata_hi  in  COEF_W  data for addr_hi, RD_LAT after rd_en.
- out_data  out  OUT_W  reduced coefficient, zero-extended.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when high with out_valid.
- out_last  out  1  marks coefficient N−1.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the last handshake.

## Operation
- FSM states:
  - IDLE: start=1 captures n, q_log and negacyclic, clears index i, and moves to RUN. start is ignored in every other state.
  - RUN: issues one read per cycle while credits allow, with addr_lo=i and addr_hi=i+N. Goes to DRAIN after issuing i=N−1.
  - DRAIN: no reads. When coefficient N−1 handshakes, pulse done and return to IDLE.
- Credits:
  - An issue is allowed only if fifo_count + in_flight + 1 ≤ FIFO_DEPTH.
  - in_flight counts issued words not yet written to the FIFO.
  - The FIFO therefore never overflows, and out_ready may stay low indefinitely.
- Boundary at i = N−1: the hi operand is forced to 0 because c_{2N−1} is not stored. addr_hi is still driven as 2N−1, and the memory content at that address is ignored.
- Lift: L(x) = x if x ≤ ⌊P/2⌋ = 6293504, else x − P. The result is signed, COEF_W+1 bits.
- Combine:
  - s = L(lo) + L(hi), or L(lo) − L(hi) when the negacyclic fold is active.
  - s is COEF_W+2 bits signed.
  - out_data = s[q_log−1:0], i.e. s mod 2^q_log (two's complement), with bits ≥ q_log set to 0.
- Ordering: coefficients leave in index order 0…N−1. out_last is asserted together with coefficient N−1.
- Reset (any state, including mid-run): FSM returns to IDLE and FIFO, in_flight and pipeline valids clear. A subsequent start runs a full sequence from i=0.

## Timing
- Reset values of all outputs: rd_en, out_valid, out_last, busy and done are 0; addr_lo, addr_hi and out_data are 0.
- With start sampled high at edge E0:
  - busy=1 after E0.
  - First rd_en is in the cycle after E0.
- For a read issued in cycle t:
  - rdata is valid at t+RD_LAT.
  - Lift register loads at t+RD_LAT+1.
  - Combine register loads at t+RD_LAT+2.
  - FIFO write occurs at t+RD_LAT+3.
- The FIFO is first-word-fall-through. out_valid rises the cycle after the write of a word into an empty FIFO.
- Minimum latency from start to first out_valid is RD_LAT+4 cycles.
- Throughput is 1 coefficient per cycle while out_ready=1.
- FIFO write and read may occur in the same cycle, including at full or empty.
- done pulses in the cycle after the handshake of coefficient N−1. busy falls with done.

## Configuration
- `POLY_FOLD_NEGACYCLIC_EN`:
  - Defined: negacyclic=1 selects subtraction (mod x^N+1), and negacyclic=0 selects addition.
  - Undefined: the negacyclic port is ignored, the fold is always addition (x^N−1, NTRU), and the subtract path is not synthesised.

## Test plan
- Plain fold: N=4, q_log=11, lo=[1,2,3,4], hi=[5,6,7,x] → outputs 6,8,10,4. out_last on the 4th output, then done pulses once.
- Lift: N=2, q_log=11, lo=[P−1, 6293505], hi=[0, 0] → outputs 2047 and (6293505−P) mod 2048 = 0.
- Backpressure: N=16, out_ready held low for 20 cycles → at most FIFO_DEPTH words outstanding (FIFO plus in flight), and all 16 values arrive correct and in order once out_ready rises.
- Negacyclic (macro defined): N=4, q_log=11, lo=[1,2,3,4], hi=[5,6,7,x] → outputs 2044,2044,2044,4.
- Reset mid-run: resetn pulses after 3 outputs → all outputs are at reset values next cycle. A new start with the same data yields the full sequence from index 0.
- start during RUN is ignored: the output count stays N and done pulses exactly once.

Source files
------------

// File: rtl/poly_fold_reduce.sv
// poly_fold_reduce
//   Output stage of the NTT polynomial multiplier. It reads the 2N-word
//   linear product from the result BRAMs (low half at i, high half at i+N).
//   Each word is lifted from [0,P) into a centred signed value. The two
//   halves are folded together, the sum is reduced modulo 2^q_log, and the
//   coefficients are streamed out through a small first-word-fall-through
//   FIFO. Reads are gated by credits so that the FIFO can never overflow.
//
//   Optional feature macro: POLY_FOLD_NEGACYCLIC_EN
//     defined   : negacyclic=1 folds by subtraction (mod x^N+1), 0 by addition
//     undefined : always folds by addition (mod x^N-1); no subtract path
//
// Ports
//   clk, resetn          clock; asynchronous active-high reset (1 = reset)
//   start                one-cycle request, sampled only while idle
//   n, q_log, negacyclic ring size, output modulus exponent, fold select
//                        (all captured on start)
//   rd_en, addr_lo/hi    read strobe and addresses i / i+N for both ports
//   rdata_lo/hi          read data, RD_LAT cycles after rd_en
//   out_data/valid/ready ready/valid coefficient stream, out_last on N-1
//   busy, done           high outside idle; one-cycle pulse when finished
module poly_fold_reduce #(
   parameter int COEF_W     = 24,
   parameter int OUT_W      = 13,
   parameter int LOG_N_MAX  = 11,
   parameter int P          = 12587009,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [LOG_N_MAX-1:0] n,
   input  logic [3:0]           q_log,
   input  logic                 negacyclic,
   output logic                 rd_en,
   output logic [LOG_N_MAX:0]   addr_lo,
   output logic [LOG_N_MAX:0]   addr_hi,
   input  logic [COEF_W-1:0]    rdata_lo,
   input  logic [COEF_W-1:0]    rdata_hi,
   output logic [OUT_W-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [COEF_W-1:0] P_W    = COEF_W'(P);
   localparam logic [COEF_W-1:0] HALF_P = COEF_W'(P / 2);
   localparam logic [OUT_W-1:0]  P_LOW  = P_W[OUT_W-1:0];

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t               state_q, state_d;
   logic [LOG_N_MAX-1:0] n_q, n_d;
   logic [LOG_N_MAX-1:0] idx_q, idx_d;
   logic [3:0]           q_log_q, q_log_d;
   logic                 done_q, done_d;
   logic [RD_LAT-1:0]    vld_pipe_q, vld_pipe_d;
   logic [RD_LAT-1:0]    last_pipe_q, last_pipe_d;
   logic [OUT_W-1:0]     lift_lo_q, lift_lo_d, lift_hi_q, lift_hi_d;
   logic                 lift_vld_q, lift_vld_d, lift_last_q, lift_last_d;
   logic [OUT_W-1:0]     comb_data_q, comb_data_d;
   logic                 comb_vld_q, comb_vld_d, comb_last_q, comb_last_d;
   logic [CNT_W-1:0]     in_flight_q, in_flight_d;
   logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OUT_W:0]       fifo_mem [FIFO_DEPTH];   // {last, data}

   logic                 idx_is_last, credit_ok, push, pop;
   logic [CNT_W:0]       credit_used;
   logic [OUT_W-1:0]     q_mask, fold_sum;
   logic [OUT_W:0]       fifo_head;

`ifdef POLY_FOLD_NEGACYCLIC_EN
   logic neg_q, neg_d;
`else
   logic unused_negacyclic;
   assign unused_negacyclic = negacyclic;
`endif

   // Only the low OUT_W bits of the lifted value can ever reach the output
   // (the final reduction is mod 2^q_log with q_log <= OUT_W), so the lift
   // is evaluated modulo 2^OUT_W: the comparison uses the full word, the
   // subtraction of P only its low bits.
   function automatic logic [OUT_W-1:0] lift_low(input logic [COEF_W-1:0] x);
      if (x > HALF_P)
         return x[OUT_W-1:0] - P_LOW;
      else
         return x[OUT_W-1:0];
   endfunction

   assign idx_is_last = (idx_q == n_q - LOG_N_MAX'(1));
   // Everything issued but not yet popped must fit in the FIFO.
   assign credit_used = {1'b0, fifo_count_q} + {1'b0, in_flight_q} + (CNT_W + 1)'(1);
   assign credit_ok   = (credit_used <= (CNT_W + 1)'(FIFO_DEPTH));
   assign rd_en       = (state_q == S_RUN) && credit_ok;
   assign addr_lo     = {1'b0, idx_q};
   assign addr_hi     = {1'b0, idx_q} + {1'b0, n_q};
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;

   assign fifo_head = fifo_mem[rd_ptr_q];
   assign out_valid = (fifo_count_q != '0);
   assign out_data  = out_valid ? fifo_head[OUT_W-1:0] : '0;
   assign out_last  = out_valid & fifo_head[OUT_W];
   assign push      = comb_vld_q;
   assign pop       = out_valid & out_ready;

   // Control FSM
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      q_log_d = q_log_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
`ifdef POLY_FOLD_NEGACYCLIC_EN
      neg_d   = neg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               n_d     = n;
               q_log_d = q_log;
               idx_d   = '0;
`ifdef POLY_FOLD_NEGACYCLIC_EN
               neg_d   = negacyclic;
`endif
            end
         end
         S_RUN: begin
            if (rd_en) begin
               idx_d = idx_q + LOG_N_MAX'(1);
               if (idx_is_last)
                  state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && fifo_head[OUT_W]) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: read-latency valid pipe, lift stage, fold/reduce stage, FIFO
   always_comb begin
      vld_pipe_d     = '0;
      last_pipe_d    = '0;
      vld_pipe_d[0]  = rd_en;
      last_pipe_d[0] = rd_en & idx_is_last;
      for (int k = 1; k < RD_LAT; k++) begin
         vld_pipe_d[k]  = vld_pipe_q[k-1];
         last_pipe_d[k] = last_pipe_q[k-1];
      end

      lift_vld_d  = vld_pipe_q[RD_LAT-1];
      lift_last_d = last_pipe_q[RD_LAT-1];
      lift_lo_d   = lift_low(rdata_lo);
      // c_{2N-1} is not stored: the high operand of the last index is zero.
      lift_hi_d   = last_pipe_q[RD_LAT-1] ? '0 : lift_low(rdata_hi);

`ifdef POLY_FOLD_NEGACYCLIC_EN
      fold_sum = neg_q ? (lift_lo_q - lift_hi_q) : (lift_lo_q + lift_hi_q);
`else
      fold_sum = lift_lo_q + lift_hi_q;
`endif
      q_mask      = ~({OUT_W{1'b1}} << q_log_q);
      comb_data_d = fold_sum & q_mask;
      comb_vld_d  = lift_vld_q;
      comb_last_d = lift_last_q;

      in_flight_d  = in_flight_q + CNT_W'(rd_en) - CNT_W'(push);
      fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state_q      <= S_IDLE;
         n_q          <= '0;
         idx_q        <= '0;
         q_log_q      <= '0;
         done_q       <= 1'b0;
         vld_pipe_q   <= '0;
         last_pipe_q  <= '0;
         lift_lo_q    <= '0;
         lift_hi_q    <= '0;
         lift_vld_q   <= 1'b0;
         lift_last_q  <= 1'b0;
         comb_data_q  <= '0;
         comb_vld_q   <= 1'b0;
         comb_last_q  <= 1'b0;
         in_flight_q  <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
`ifdef POLY_FOLD_NEGACYCLIC_EN
         neg_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         idx_q        <= idx_d;
         q_log_q      <= q_log_d;
         done_q       <= done_d;
         vld_pipe_q   <= vld_pipe_d;
         last_pipe_q  <= last_pipe_d;
         lift_lo_q    <= lift_lo_d;
         lift_hi_q    <= lift_hi_d;
         lift_vld_q   <= lift_vld_d;
         lift_last_q  <= lift_last_d;
         comb_data_q  <= comb_data_d;
         comb_vld_q   <= comb_vld_d;
         comb_last_q  <= comb_last_d;
         in_flight_q  <= in_flight_d;
         fifo_count_q <= fifo_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
`ifdef POLY_FOLD_NEGACYCLIC_EN
         neg_q        <= neg_d;
`endif
      end
   end

   // FIFO storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_q] <= {comb_last_q, comb_data_q};
   end

endmodule

// File: tb/tb_poly_fold_reduce.sv
// Self-checking bench for poly_fold_reduce. A behavioural memory model
// answers reads after RD_LAT cycles; expected coefficients come from a
// reference model that applies the lift / fold / mod 2^q_log rules with
// plain integer arithmetic.
module tb_poly_fold_reduce;

   localparam int COEF_W     = 24;
   localparam int OUT_W      = 13;
   localparam int LOG_N_MAX  = 11;
   localparam int P          = 12587009;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 8;

   logic                 clk = 1'b0;
   logic                 resetn = 1'b1;
   logic                 start = 1'b0;
   logic [LOG_N_MAX-1:0] n = '0;
   logic [3:0]           q_log = '0;
   logic                 negacyclic = 1'b0;
   logic                 rd_en;
   logic [LOG_N_MAX:0]   addr_lo, addr_hi;
   logic [COEF_W-1:0]    rdata_lo, rdata_hi;
   logic [OUT_W-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic                 out_last, busy, done;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [COEF_W-1:0] mem [0:4095];
   logic [COEF_W-1:0] lo_pipe [RD_LAT];
   logic [COEF_W-1:0] hi_pipe [RD_LAT];

   int got_data[$];
   bit got_last[$];
   int done_cnt, max_out, first_valid_cyc;
   bit timed_out, busy_at_done;

   always #5 clk = ~clk;

   poly_fold_reduce #(
      .COEF_W(COEF_W), .OUT_W(OUT_W), .LOG_N_MAX(LOG_N_MAX), .P(P),
      .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .n(n), .q_log(q_log),
      .negacyclic(negacyclic), .rd_en(rd_en), .addr_lo(addr_lo),
      .addr_hi(addr_hi), .rdata_lo(rdata_lo), .rdata_hi(rdata_hi),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   // BRAM model with RD_LAT cycles of read latency
   always @(posedge clk) begin
      lo_pipe[0] <= mem[addr_lo];
      hi_pipe[0] <= mem[addr_hi];
      for (int k = 1; k < RD_LAT; k++) begin
         lo_pipe[k] <= lo_pipe[k-1];
         hi_pipe[k] <= hi_pipe[k-1];
      end
   end
   assign rdata_lo = lo_pipe[RD_LAT-1];
   assign rdata_hi = hi_pipe[RD_LAT-1];

   function automatic longint lift_ref(longint x);
      return (x > P / 2) ? x - P : x;
   endfunction

   function automatic int model_coef(int i, int nn, int ql, bit neg);
      longint lo = mem[i];
      longint hi = (i == nn - 1) ? 0 : mem[i + nn];
      longint m  = longint'(1) << ql;
      longint s, r;
      bit sub;
`ifdef POLY_FOLD_NEGACYCLIC_EN
      sub = neg;
`else
      sub = neg & 1'b0;
`endif
      s = sub ? lift_ref(lo) - lift_ref(hi) : lift_ref(lo) + lift_ref(hi);
      r = s % m;
      if (r < 0) r += m;
      return int'(r);
   endfunction

   task automatic fill_random(input int nn);
      for (int i = 0; i < 2 * nn - 1; i++) begin
         case ($urandom_range(0, 7))
            0: mem[i] = '0;
            1: mem[i] = COEF_W'(P - 1);
            2: mem[i] = COEF_W'(P / 2);
            3: mem[i] = COEF_W'(P / 2 + 1);
            default: mem[i] = COEF_W'($urandom_range(0, P - 1));
         endcase
      end
      mem[2 * nn - 1] = COEF_W'($urandom);   // never stored; must be ignored
   endtask

   // Drives one start and collects every handshake until done (plus a tail).
   task automatic run_seq(input int nn, input int ql, input bit neg, input int stall,
                          input bit rnd_ready, input int extra_start_cyc, input int abort_after);
      int issued = 0, popped = 0, cyc = 0, tail = 0;
      bit finished = 0;
      got_data.delete(); got_last.delete();
      done_cnt = 0; max_out = 0; first_valid_cyc = -1; timed_out = 0; busy_at_done = 1;
      n = LOG_N_MAX'(nn); q_log = 4'(ql); negacyclic = neg; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (1) begin
         if (cyc < stall)    out_ready = 1'b0;
         else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
         else                out_ready = 1'b1;
         if (cyc == extra_start_cyc) begin
            start = 1'b1; n = LOG_N_MAX'(2); q_log = 4'd1;
         end else begin
            start = 1'b0;
         end
         if (rd_en) issued++;
         if (issued - popped > max_out) max_out = issued - popped;
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (done) begin
            done_cnt++; busy_at_done = busy; finished = 1;
         end
         if (out_valid && out_ready) begin
            got_data.push_back(int'(out_data));
            got_last.push_back(out_last);
            popped++;
            $display("coef %0d data=%0d last=%0b", got_data.size() - 1, out_data, out_last);
         end
         if (abort_after >= 0 && got_data.size() == abort_after) break;
         if (finished) tail++;
         if (tail > 6) break;
         cyc++;
         if (cyc > 4000) begin
            timed_out = 1; break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++; if ({rd_en, out_valid, out_last, busy, done} !== 5'b0) $display("FAIL reset_flags got=%b exp=00000", {rd_en, out_valid, out_last, busy, done}); else pass_cnt++;
      chk_cnt++; if (addr_lo !== '0) $display("FAIL reset_addr_lo got=%0d exp=0", addr_lo); else pass_cnt++;
      chk_cnt++; if (addr_hi !== '0) $display("FAIL reset_addr_hi got=%0d exp=0", addr_hi); else pass_cnt++;
      chk_cnt++; if (out_data !== '0) $display("FAIL reset_out_data got=%0d exp=0", out_data); else pass_cnt++;
      resetn = 1'b0;
      @(posedge clk); #1;
      chk_cnt++; if ({rd_en, busy, out_valid} !== 3'b0) $display("FAIL idle_after_reset got=%b exp=000", {rd_en, busy, out_valid}); else pass_cnt++;
   endtask

   task automatic test_plain_fold();
      int exp_v[4] = '{6, 8, 10, 4};
      mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
      mem[4] = 5; mem[5] = 6; mem[6] = 7; mem[7] = 24'hABCDEF;
      run_seq(4, 11, 1'b0, 0, 1'b0, -1, -1);
      chk_cnt++; if (timed_out) $display("FAIL plain_timeout got=1 exp=0"); else pass_cnt++;
      chk_cnt++; if (got_data.size() != 4) $display("FAIL plain_count got=%0d exp=4", got_data.size()); else pass_cnt++;
      for (int i = 0; i < 4 && i < got_data.size(); i++) begin
         chk_cnt++; if (got_data[i] !== exp_v[i]) $display("FAIL plain_data[%0d] got=%0d exp=%0d", i, got_data[i], exp_v[i]); else pass_cnt++;
         chk_cnt++; if (got_last[i] !== (i == 3)) $display("FAIL plain_last[%0d] got=%0b exp=%0b", i, got_last[i], i == 3); else pass_cnt++;
      end
      chk_cnt++; if (done_cnt != 1) $display("FAIL plain_done_pulses got=%0d exp=1", done_cnt); else pass_cnt++;
      chk_cnt++; if (busy_at_done !== 1'b0) $display("FAIL plain_busy_with_done got=%0b exp=0", busy_at_done); else pass_cnt++;
      // First out_valid RD_LAT+4 cycles after the start cycle.
      chk_cnt++; if (first_valid_cyc != RD_LAT + 3) $display("FAIL first_latency got=%0d exp=%0d", first_valid_cyc, RD_LAT + 3); else pass_cnt++;
   endtask

   task automatic test_negacyclic();
`ifdef POLY_FOLD_NEGACYCLIC_EN
      int exp_v[4] = '{2044, 2044, 2044, 4};
`else
      int exp_v[4] = '{6, 8, 10, 4};
`endif
      mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
      mem[4] = 5; mem[5] = 6; mem[6] = 7; mem[7] = 24'h123456;
      run_seq(4, 11, 1'b1, 0, 1'b0, -1, -1);
      chk_cnt++; if (got_data.size() != 4) $display("FAIL neg_count got=%0d exp=4", got_data.size()); else pass_cnt++;
      for (int i = 0; i < 4 && i < got_data.size(); i++) begin
         chk_cnt++; if (got_data[i] !== exp_v[i]) $display("FAIL neg_data[%0d] got=%0d exp=%0d", i, got_data[i], exp_v[i]); else pass_cnt++;
      end
   endtask

   task automatic test_lift();
      mem[0] = COEF_W'(P - 1); mem[1] = 24'd6293505; mem[2] = '0; mem[3] = 24'hFFFFFF;
      run_seq(2, 11, 1'b0, 0, 1'b0, -1, -1);
      chk_cnt++; if (got_data.size() != 2) $display("FAIL lift_count got=%0d exp=2", got_data.size()); else pass_cnt++;
      if (got_data.size() == 2) begin
         chk_cnt++; if (got_data[0] !== 2047) $display("FAIL lift_neg_one got=%0d exp=2047", got_data[0]); else pass_cnt++;
         chk_cnt++; if (got_data[1] !== 0) $display("FAIL lift_above_half got=%0d exp=0", got_data[1]); else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      int e;
      fill_random(16);
      run_seq(16, 13, 1'b0, 20, 1'b0, -1, -1);
      chk_cnt++; if (max_out > FIFO_DEPTH) $display("FAIL bp_outstanding_max got=%0d exp<=%0d", max_out, FIFO_DEPTH); else pass_cnt++;
      chk_cnt++; if (max_out < FIFO_DEPTH) $display("FAIL bp_credit_use got=%0d exp=%0d", max_out, FIFO_DEPTH); else pass_cnt++;
      chk_cnt++; if (got_data.size() != 16) $display("FAIL bp_count got=%0d exp=16", got_data.size()); else pass_cnt++;
      for (int i = 0; i < got_data.size() && i < 16; i++) begin
         e = model_coef(i, 16, 13, 1'b0);
         chk_cnt++; if (got_data[i] !== e) $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got_data[i], e); else pass_cnt++;
      end
   endtask

   task automatic test_random();
      int nn, ql, e;
      bit neg;
      for (int r = 0; r < 6; r++) begin
         nn  = $urandom_range(2, 24);
         ql  = (r == 0) ? 1 : (r == 1) ? OUT_W : $urandom_range(1, OUT_W);
         neg = 1'($urandom_range(0, 1));
         fill_random(nn);
         run_seq(nn, ql, neg, 0, 1'b1, -1, -1);
         chk_cnt++; if (timed_out || got_data.size() != nn) $display("FAIL rnd%0d_count got=%0d exp=%0d", r, got_data.size(), nn); else pass_cnt++;
         chk_cnt++; if (done_cnt != 1) $display("FAIL rnd%0d_done got=%0d exp=1", r, done_cnt); else pass_cnt++;
         for (int i = 0; i < got_data.size() && i < nn; i++) begin
            e = model_coef(i, nn, ql, neg);
            chk_cnt++; if (got_data[i] !== e) $display("FAIL rnd%0d_data[%0d] got=%0d exp=%0d", r, i, got_data[i], e); else pass_cnt++;
            chk_cnt++; if (got_last[i] !== (i == nn - 1)) $display("FAIL rnd%0d_last[%0d] got=%0b exp=%0b", r, i, got_last[i], i == nn - 1); else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int e;
      fill_random(12);
      run_seq(12, 9, 1'b1, 0, 1'b0, -1, 3);
      chk_cnt++; if (got_data.size() != 3) $display("FAIL mid_outputs_before_reset got=%0d exp=3", got_data.size()); else pass_cnt++;
      resetn = 1'b1;
      #1;
      chk_cnt++; if ({rd_en, out_valid, out_last, busy, done} !== 5'b0) $display("FAIL mid_reset_flags got=%b exp=00000", {rd_en, out_valid, out_last, busy, done}); else pass_cnt++;
      chk_cnt++; if ({addr_lo, addr_hi, out_data} !== '0) $display("FAIL mid_reset_data got=%0h exp=0", {addr_lo, addr_hi, out_data}); else pass_cnt++;
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      run_seq(12, 9, 1'b1, 0, 1'b1, -1, -1);
      chk_cnt++; if (got_data.size() != 12) $display("FAIL mid_rerun_count got=%0d exp=12", got_data.size()); else pass_cnt++;
      for (int i = 0; i < got_data.size() && i < 12; i++) begin
         e = model_coef(i, 12, 9, 1'b1);
         chk_cnt++; if (got_data[i] !== e) $display("FAIL mid_rerun_data[%0d] got=%0d exp=%0d", i, got_data[i], e); else pass_cnt++;
      end
   endtask

   task automatic test_start_ignored();
      int e;
      fill_random(8);
      run_seq(8, 12, 1'b0, 0, 1'b0, 3, -1);
      chk_cnt++; if (got_data.size() != 8) $display("FAIL busy_start_count got=%0d exp=8", got_data.size()); else pass_cnt++;
      chk_cnt++; if (done_cnt != 1) $display("FAIL busy_start_done got=%0d exp=1", done_cnt); else pass_cnt++;
      for (int i = 0; i < got_data.size() && i < 8; i++) begin
         e = model_coef(i, 8, 12, 1'b0);
         chk_cnt++; if (got_data[i] !== e) $display("FAIL busy_start_data[%0d] got=%0d exp=%0d", i, got_data[i], e); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_plain_fold();
      test_negacyclic();
      test_lift();
      test_backpressure();
      test_random();
      test_reset_mid_run();
      test_start_ignored();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
